// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester single-bus arbiter with fetch starvation guard and bus watchdog
module bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_address,
  output logic        f_done,
  output logic        f_error,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic        d_error,
  output logic [31:0] d_rdata,
  output logic        bus_vaild,
  input  logic        bus_ready,
  output logic        bus_write_enable,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_data,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, BUS_F, BUS_D, RESP} state_t;
  state_t state;
  logic [3:0] starve_cnt;
  logic [15:0] wdog;
  logic expire, grant_d;
  logic [31:0] rdata_next;
  always_comb begin
    expire = (TIMEOUT != 0) && (wdog == 16'(TIMEOUT - 1));
    grant_d = d_req && (!f_req || starve_cnt < 4'(STARVE_LIMIT));
    rdata_next = bus_ready && !bus_write_enable ? bus_data : '0;
    busy = state != IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      starve_cnt <= '0;
      wdog <= '0;
      bus_vaild <= 1'b0;
      bus_write_enable <= 1'b0;
      bus_address <= '0;
      bus_write_data <= '0;
      f_done <= 1'b0;
      f_error <= 1'b0;
      f_rdata <= '0;
      d_done <= 1'b0;
      d_error <= 1'b0;
      d_rdata <= '0;
    end else begin
      f_done <= 1'b0;
      f_error <= 1'b0;
      d_done <= 1'b0;
      d_error <= 1'b0;
      case (state)
        IDLE: if (grant_d || f_req) begin
          state <= grant_d ? BUS_D : BUS_F;
          bus_vaild <= 1'b1;
          bus_address <= grant_d ? d_address : f_address;
          bus_write_enable <= grant_d && d_write;
          bus_write_data <= grant_d ? d_wdata : '0;
          starve_cnt <= grant_d && f_req ? starve_cnt + 4'd1 : '0;
          wdog <= '0;
        end
        BUS_F, BUS_D: if (bus_ready || expire) begin
          // a ready arriving in the expiry cycle wins over the timeout
          state <= RESP;
          bus_vaild <= 1'b0;
          f_done <= state == BUS_F;
          d_done <= state == BUS_D;
          f_error <= state == BUS_F && !bus_ready;
          d_error <= state == BUS_D && !bus_ready;
          f_rdata <= state == BUS_F ? rdata_next : f_rdata;
          d_rdata <= state == BUS_D ? rdata_next : d_rdata;
        end else begin
          wdog <= wdog + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive data grants while fetch is pending (legal 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of bus wait cycles before abort (0 = watchdog disabled, legal 0..65535).
REQ-003 SHALL have ports (one per line: name, direction, width, meaning):
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- f_req  in  1  fetch requester request; held until f_done
- f_address  in  32  fetch read address
- f_done  out  1  one-cycle fetch completion pulse
- f_error  out  1  fetch aborted by timeout; valid with f_done
- f_rdata  out  32  fetch read data; valid with f_done
- d_req  in  1  data requester request; held until d_done
- d_write  in  1  data access is a write
- d_address  in  32  data address
- d_wdata  in  32  data write data
- d_done  out  1  one-cycle data completion pulse
- d_error  out  1  data aborted by timeout; valid with d_done
- d_rdata  out  32  data read data; valid with d_done (0 on writes)
- bus_vaild  out  1  bus cycle valid
- bus_ready  in  1  bus cycle accepted/completed
- bus_write_enable  out  1  bus cycle is a write
- bus_address  out  32  bus address
- bus_write_data  out  32  bus write data
- bus_data  in  32  bus read data
- busy  out  1  high in any state other than IDLE

Function
REQ-004 SHALL implement states IDLE, BUS_F, BUS_D, RESP.
REQ-005 In IDLE, the block SHALL arbitrate as follows:
- no request: stay in IDLE.
- d_req only: go to BUS_D.
- f_req only: go to BUS_F.
- both requests with starve_cnt < STARVE_LIMIT: go to BUS_D and increment starve_cnt.
- both requests with starve_cnt == STARVE_LIMIT: go to BUS_F.
REQ-006 starve_cnt SHALL clear on every fetch grant; a data grant with f_req low SHALL leave starve_cnt at 0.
REQ-007 On a grant the block SHALL latch address, write flag and write data into internal registers; bus_address, bus_write_enable and bus_write_data SHALL be driven only from these registers.
REQ-008 Requester inputs SHALL be ignored outside IDLE.
REQ-009 bus_vaild SHALL be 1 in BUS_F and BUS_D and 0 in IDLE and RESP.
REQ-010 bus_write_enable SHALL be 0 for every fetch cycle.
REQ-011 bus outputs SHALL stay stable from the start of BUS_x until the handshake.
REQ-012 A handshake SHALL occur in a BUS_x cycle when bus_ready=1; the block SHALL then capture bus_data (reads) and go to RESP.
REQ-013 In RESP, the owner's x_done SHALL be 1 for exactly one cycle, with x_rdata and x_error valid; the next state SHALL be IDLE.
REQ-014 The requester SHALL drop x_req during RESP; a request still high in the following IDLE cycle SHALL be treated as a new request.
REQ-015 Latency SHALL be:
- request sampled in IDLE at cycle N -> bus_vaild high at N+1.
- bus_ready at cycle M -> x_done at M+1.
- next grant decision no earlier than M+2.
REQ-016 The watchdog counter SHALL clear on entry to BUS_x and increment each BUS_x cycle with bus_ready=0.
REQ-017 When the watchdog reaches TIMEOUT (TIMEOUT != 0), the block SHALL go to RESP with x_error=1 and x_rdata=0; a bus_ready in that same cycle SHALL take priority, giving a normal completion.
REQ-018 x_rdata SHALL hold its value until the next completion of the same requester.
REQ-019 x_done and x_error SHALL be 0 except in RESP.

Reset
REQ-020 While reset=1 at a clock edge, the block SHALL go to IDLE and clear starve_cnt and the watchdog; this applies mid-cycle too, abandoning any bus cycle with no x_done.
REQ-021 Reset values SHALL be: bus_vaild=0, bus_write_enable=0, bus_address=0, bus_write_data=0, f_done=0, f_error=0, f_rdata=0, d_done=0, d_error=0, d_rdata=0, busy=0.

Verification
REQ-022 Fetch read: f_req=1, f_address=0x0000FFF0, bus_ready=1 two cycles after bus_vaild -> bus_address=0x0000FFF0, bus_write_enable=0, f_done one cycle after ready, f_rdata=bus_data value (e.g. 0x90909090).
REQ-023 Data write: d_req=1, d_write=1, d_address=0x1000, d_wdata=0xDEADBEEF, immediate bus_ready -> bus_write_enable=1, bus_write_data=0xDEADBEEF, d_done=1, d_rdata=0, d_error=0.
REQ-024 Starvation: f_req and d_req held continuously, each requester re-requesting after done, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-025 Timeout: TIMEOUT=3, bus_ready held 0 -> bus_vaild high exactly 3 cycles, then x_done=1 with x_error=1; with TIMEOUT=0 and bus_ready=0 held for 1000 cycles -> no completion.
REQ-026 Reset mid-cycle: reset asserted during BUS_D -> next cycle bus_vaild=0, busy=0, no d_done; a following f_req is served normally.
REQ-027 Timeout/ready collision: bus_ready=1 in the same cycle the watchdog reaches TIMEOUT -> normal completion, x_error=0, x_rdata=bus_data.
